// File: rtl/cnn_ram_pkg.sv
`default_nettype none
// ============================================================================
// cnn_ram_pkg : shared RAM geometry and arbiter defaults for the CNN engines
// Revision 1.0 : initial release
// ============================================================================
package cnn_ram_pkg;

  localparam int RAM_ADDR_W    = 16;
  localparam int RAM_DATA_W    = 16;
  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_BURST_MAX = 4;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_e;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// rr_priority_picker : first set request scanning ptr, ptr+1, ... mod NUM_REQ
// Revision 1.0 : initial release
// ============================================================================
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    w_sum  = '0;
    w_pos  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One conditional subtract suffices: ptr < NUM_REQ and k < NUM_REQ.
      w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!found && req[w_pos]) begin
        found         = 1'b1;
        idx           = w_pos;
        onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter : round-robin, burst-bounded sharing of one 1-cycle RAM port
// Revision 1.0 : initial release
// ============================================================================
module ram_port_arbiter
  import cnn_ram_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rvalid,
  output logic [NUM_REQ-1:0]        rid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam int                 CNT_W     = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]   BURST_LIM = CNT_W'(BURST_MAX);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner_idx;
  logic               r_owner_vld;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [DATA_W-1:0]  r_last_data;
  logic               r_rvalid;
  logic [NUM_REQ-1:0] r_rid;

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_owner_mask;
  logic [NUM_REQ-1:0] w_others;
  logic               w_keep;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [CNT_W-1:0]   w_cnt_next;
  acc_kind_e          w_acc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign w_data[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .found  (w_pick_found)
  );

  // The current owner may run past BURST_MAX only when nobody else is waiting.
  assign w_owner_mask = ONE_HOT0 << r_owner_idx;
  assign w_others     = req & ~w_owner_mask;
  assign w_keep       = r_owner_vld && req[r_owner_idx] &&
                        ((r_burst_cnt < BURST_LIM) || !(|w_others));

  always_comb begin
    gnt       = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (!rst) begin
      if (w_keep) begin
        gnt       = w_owner_mask;
        w_gnt_idx = r_owner_idx;
        w_gnt_any = 1'b1;
      end else if (w_pick_found) begin
        gnt       = w_pick_onehot;
        w_gnt_idx = w_pick_idx;
        w_gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_acc    = ACC_NONE;
    ram_addr = r_last_addr;
    ram_data = r_last_data;
    if (w_gnt_any) begin
      w_acc    = req_we[w_gnt_idx] ? ACC_WRITE : ACC_READ;
      ram_addr = w_addr[w_gnt_idx];
      ram_data = w_data[w_gnt_idx];
    end
    ram_we = (w_acc == ACC_WRITE);
  end

  always_comb begin
    w_ptr_next = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + IDX_W'(1);
    if (!r_owner_vld || (r_owner_idx != w_gnt_idx)) begin
      w_cnt_next = CNT_W'(1);
    end else if (r_burst_cnt == BURST_LIM) begin
      w_cnt_next = BURST_LIM;
    end else begin
      w_cnt_next = r_burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner_idx <= '0;
      r_owner_vld <= 1'b0;
      r_burst_cnt <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
      r_rvalid    <= 1'b0;
      r_rid       <= '0;
    end else begin
      r_rvalid <= (w_acc == ACC_READ);
      r_rid    <= (w_acc == ACC_READ) ? gnt : '0;
      if (w_gnt_any) begin
        r_owner_vld <= 1'b1;
        r_owner_idx <= w_gnt_idx;
        r_burst_cnt <= w_cnt_next;
        r_ptr       <= w_ptr_next;
        r_last_addr <= ram_addr;
        r_last_data <= ram_data;
      end else begin
        r_owner_vld <= 1'b0;
        r_burst_cnt <= '0;
      end
    end
  end

  assign rvalid = r_rvalid;
  assign rid    = r_rid;
  assign rdata  = ram_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_port_arbiter : directed scoreboard bench for ram_port_arbiter
// Revision 1.0 : initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [15:0] a_in [3];
  logic [15:0] d_in [3];
  logic [47:0] req_addr;
  logic [47:0] req_data;
  logic [2:0]  gnt;
  logic        rvalid;
  logic [2:0]  rid;
  logic [15:0] rdata;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [15:0] ram_q;

  assign req_addr = {a_in[2], a_in[1], a_in[0]};
  assign req_data = {d_in[2], d_in[1], d_in[0]};

  ram_port_arbiter #(
    .NUM_REQ   (3),
    .ADDR_W    (16),
    .DATA_W    (16),
    .BURST_MAX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rid      (rid),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read; unwritten words hold a fixed pattern.
  logic [15:0] mem [logic [15:0]];
  always @(posedge clk) begin
    ram_q <= mem.exists(ram_addr) ? mem[ram_addr] : (ram_addr ^ 16'hA5A5);
    if (ram_we) mem[ram_addr] = ram_data;
  end

  typedef struct packed {
    logic [2:0]  rid;
    logic [15:0] data;
  } sb_item_t;

  sb_item_t    sb [$];
  logic [15:0] shadow [logic [15:0]];
  logic [15:0] last_addr;
  int          n_pass;
  int          n_total;

  function automatic logic [15:0] exp_mem(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : (a ^ 16'hA5A5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick(input logic [2:0] exp_gnt);
    sb_item_t    e;
    logic [15:0] a;
    int          g;
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rvalid", 32'(rvalid), 32'd1);
      check("rid", 32'(rid), 32'(e.rid));
      check("rdata", 32'(rdata), 32'(e.data));
    end else begin
      check("rvalid_idle", 32'(rvalid), 32'd0);
      check("rid_idle", 32'(rid), 32'd0);
    end
    if (exp_gnt == 3'b000) begin
      check("ram_we_idle", 32'(ram_we), 32'd0);
      if (!rst) check("ram_addr_hold", 32'(ram_addr), 32'(last_addr));
    end else begin
      g = 0;
      for (int i = 0; i < 3; i++) if (exp_gnt[i]) g = i;
      a = a_in[g];
      check("ram_addr", 32'(ram_addr), 32'(a));
      if (req_we[g]) begin
        check("ram_we_wr", 32'(ram_we), 32'd1);
        check("ram_data", 32'(ram_data), 32'(d_in[g]));
        shadow[a] = d_in[g];
      end else begin
        check("ram_we_rd", 32'(ram_we), 32'd0);
        e.rid  = exp_gnt;
        e.data = exp_mem(a);
        sb.push_back(e);
      end
      last_addr = a;
    end
    if (rst) last_addr = 16'h0000;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] r, input logic [2:0] we);
    req    = r;
    req_we = we;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    last_addr = 16'h0000;
    rst       = 1'b1;
    req       = 3'b000;
    req_we    = 3'b000;
    a_in[0] = 16'h0010; a_in[1] = 16'h0100; a_in[2] = 16'h0200;
    d_in[0] = 16'h0000; d_in[1] = 16'h0000; d_in[2] = 16'h0000;
    @(posedge clk);
    @(negedge clk);

    // Reset holds off every request, then requester 0 wins first
    set_req(3'b111, 3'b000);
    tick(3'b000);
    tick(3'b000);
    rst = 1'b0;
    tick(3'b001);

    // Write then read back the same address
    set_req(3'b001, 3'b001);
    d_in[0] = 16'hBEEF;
    tick(3'b001);
    set_req(3'b001, 3'b000);
    tick(3'b001);
    set_req(3'b000, 3'b000);
    tick(3'b000);

    // Three contending readers: bursts of four, rotating
    rst = 1'b1;
    tick(3'b000);
    rst = 1'b0;
    set_req(3'b111, 3'b000);
    for (int i = 0; i < 4; i++) tick(3'b001);
    for (int i = 0; i < 4; i++) tick(3'b010);
    for (int i = 0; i < 4; i++) tick(3'b100);
    tick(3'b001);
    tick(3'b001);

    // Lone requester is never cut off; contention then caps it
    a_in[1] = 16'h0300;
    set_req(3'b010, 3'b000);
    for (int i = 0; i < 10; i++) tick(3'b010);
    set_req(3'b011, 3'b000);
    for (int i = 0; i < 4; i++) tick(3'b001);
    tick(3'b010);

    // Reset in the middle of continuous reads
    set_req(3'b111, 3'b000);
    tick(3'b010);
    rst = 1'b1;
    tick(3'b000);
    rst = 1'b0;
    tick(3'b001);
    set_req(3'b000, 3'b000);
    tick(3'b000);

    // Same-cycle write and read of the top address
    rst = 1'b1;
    tick(3'b000);
    rst = 1'b0;
    a_in[0] = 16'hFFFF; d_in[0] = 16'h1234;
    a_in[1] = 16'hFFFF;
    set_req(3'b011, 3'b001);
    tick(3'b001);
    set_req(3'b010, 3'b000);
    tick(3'b010);
    set_req(3'b000, 3'b000);
    tick(3'b000);
    tick(3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
